game_countdown: RTL
===================

GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, the number of enabled clk cycles per one-second decrement; legal range 2..2^26.
REQ-002 SHALL have parameter START_MIN, default 4'd2, the minutes digit loaded on reset/load; legal range 0..9.
REQ-003 SHALL have parameter START_SEC_TENS, default 4'd0, the seconds-tens digit loaded; legal range 0..5.
REQ-004 SHALL have parameter START_SEC_ONES, default 4'd0, the seconds-ones digit loaded; legal range 0..9.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port countLoadN, input, 1 bit, active-low load-start-value command from the game timer FSM.
REQ-008 SHALL have port countEnable, input, 1 bit: when high, the prescaler advances and the countdown runs.
REQ-009 SHALL have port minDigit, output, 4 bits, BCD minutes.
REQ-010 SHALL have port secTens, output, 4 bits, BCD seconds tens.
REQ-011 SHALL have port secOnes, output, 4 bits, BCD seconds ones.
REQ-012 SHALL have port oneSecTick, output, 1 bit, a one-cycle pulse on each decrement.
REQ-013 SHALL have port timerEnd, output, 1 bit: high while the count is 0:00; consumed by the game timer FSM.

Function
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-015 Priority per edge SHALL be: reset > load (countLoadN=0) > countdown (countEnable=1) > hold.
REQ-016 Load SHALL set the digits to START_MIN:START_SEC_TENS START_SEC_ONES, clear the prescaler, clear oneSecTick, and set timerEnd = (start value == 0:00), all on the same edge.
REQ-017 Prescaler SHALL be a 26-bit counter, 0..TICK_DIV-1, advancing only on edges with countEnable=1 and count != 0:00; it SHALL wrap to 0 after TICK_DIV-1.
REQ-018 A decrement SHALL occur on the enabled edge where prescaler == TICK_DIV-1; the first decrement after load SHALL therefore land on the TICK_DIV-th enabled edge.
REQ-019 With countEnable=0, prescaler, digits and timerEnd SHALL hold; oneSecTick SHALL be 0.
REQ-020 Decrement SHALL be BCD with borrow: secOnes 0->9 borrows from secTens; secTens 0->5 borrows from minDigit; a digit that does not underflow decrements by 1.
REQ-021 Count SHALL saturate at 0:00: no decrement, no wrap to 9:59, prescaler frozen, oneSecTick stays 0.
REQ-022 timerEnd SHALL assert on the same edge the digits become 0:00 and stay high until load or reset.
REQ-023 oneSecTick SHALL be high for exactly the cycle following each decrement edge, including the final 0:01->0:00 decrement.
REQ-024 Load during countdown SHALL abort the count and restart from the start value, with the prescaler at 0.

Reset
REQ-025 On reset=1 at a clk edge: digits = start value, prescaler = 0, oneSecTick = 0, timerEnd = (start value == 0:00); countLoadN and countEnable are ignored that cycle.
REQ-026 Reset asserted mid-countdown SHALL take effect on the next edge with no partial decrement.

Verification (TICK_DIV=4, defaults otherwise)
REQ-027 Reset 1 cycle -> 2:00, timerEnd=0, oneSecTick=0.
REQ-028 Load, then countEnable=1 continuously -> 1:59 after the 4th enabled edge, with oneSecTick high for 1 cycle; 1:58 four edges later.
REQ-029 Borrow chain: from 1:00 one decrement -> 0:59; from 0:10 -> 0:09; from 0:00 (START=0:00) -> no change, timerEnd=1 immediately after load.
REQ-030 Full run from 2:00 -> timerEnd rises on the 480th enabled edge with digits 0:00; it holds 0:00 and timerEnd=1 for 20 more enabled cycles.
REQ-031 countEnable dropped after 2 enabled cycles for 10 cycles, then restored -> decrement after 2 more enabled edges (prescaler retained).
REQ-032 countLoadN=0 and countEnable=1 together at 1:37 -> 2:00, prescaler 0; reset=1 together with countLoadN=0 -> reset values.

Source files
------------

// File: rtl/game_countdown_if.sv
// rtl/game_countdown_if.sv - control and BCD display signals between the game timer FSM and the countdown
interface game_countdown_if;
    logic       countLoadN;
    logic       countEnable;
    logic [3:0] minDigit;
    logic [3:0] secTens;
    logic [3:0] secOnes;
    logic       oneSecTick;
    logic       timerEnd;

    modport master (
        output countLoadN, countEnable,
        input  minDigit, secTens, secOnes, oneSecTick, timerEnd
    );

    modport slave (
        input  countLoadN, countEnable,
        output minDigit, secTens, secOnes, oneSecTick, timerEnd
    );
endinterface

// File: rtl/game_countdown.sv
// rtl/game_countdown.sv - M:SS BCD countdown with one-second prescaler, saturating at 0:00
module game_countdown #(
    parameter int         TICK_DIV       = 50000000,
    parameter logic [3:0] START_MIN      = 4'd2,
    parameter logic [3:0] START_SEC_TENS = 4'd0,
    parameter logic [3:0] START_SEC_ONES = 4'd0
) (
    input  logic            clk,
    input  logic            reset,
    game_countdown_if.slave cd
);

    localparam logic [25:0] PRESC_MAX  = 26'(TICK_DIV - 1);
    localparam logic        START_ZERO = (START_MIN == 4'd0) && (START_SEC_TENS == 4'd0)
                                         && (START_SEC_ONES == 4'd0);

    logic [25:0] prescaler;
    logic [3:0]  minReg;
    logic [3:0]  tensReg;
    logic [3:0]  onesReg;
    logic        tickReg;
    logic        endReg;

    logic        countZero;
    logic        decZero;
    logic [3:0]  minDec;
    logic [3:0]  tensDec;
    logic [3:0]  onesDec;

    assign countZero = (minReg == 4'd0) && (tensReg == 4'd0) && (onesReg == 4'd0);

    // Borrow chain; only used when the count is nonzero, so minutes never underflow
    always_comb begin
        minDec  = minReg;
        tensDec = tensReg;
        onesDec = onesReg - 4'd1;
        if (onesReg == 4'd0) begin
            onesDec = 4'd9;
            tensDec = tensReg - 4'd1;
            if (tensReg == 4'd0) begin
                tensDec = 4'd5;
                minDec  = minReg - 4'd1;
            end
        end
    end

    assign decZero = (minDec == 4'd0) && (tensDec == 4'd0) && (onesDec == 4'd0);

    always_ff @(posedge clk) begin
        if (reset || !cd.countLoadN) begin
            prescaler <= '0;
            minReg    <= START_MIN;
            tensReg   <= START_SEC_TENS;
            onesReg   <= START_SEC_ONES;
            tickReg   <= 1'b0;
            endReg    <= START_ZERO;
        end else if (cd.countEnable && !countZero) begin
            if (prescaler == PRESC_MAX) begin
                prescaler <= '0;
                minReg    <= minDec;
                tensReg   <= tensDec;
                onesReg   <= onesDec;
                tickReg   <= 1'b1;
                endReg    <= decZero;
            end else begin
                prescaler <= prescaler + 26'd1;
                tickReg   <= 1'b0;
            end
        end else begin
            tickReg <= 1'b0;
        end
    end

    assign cd.minDigit   = minReg;
    assign cd.secTens    = tensReg;
    assign cd.secOnes    = onesReg;
    assign cd.oneSecTick = tickReg;
    assign cd.timerEnd   = endReg;

endmodule
